// File: rtl/ram_arb_pkg.sv
// Shared state encoding and sizing constants for the RAM64 arbiter.
package ram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 16;
    localparam int PORT0      = 0;
    localparam int PORT1      = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant: round-robin when FAIR != 0, else fixed priority to port 0.
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if ((FAIR != 0) && ptr_q) begin
            gnt[PORT1] = req[PORT1];
            gnt[PORT0] = req[PORT0] & ~req[PORT1];
        end else begin
            gnt[PORT0] = req[PORT0];
            gnt[PORT1] = req[PORT1] & ~req[PORT0];
        end
        // Next preference goes to whichever port did not just win.
        ptr_d = ptr_q;
        if (gnt[PORT0]) begin
            ptr_d = 1'b1;
        end else if (gnt[PORT1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram64_arbiter.sv
// Two-port arbiter/sequencer in front of a RAM64 macro, one access per 2 cycles.
// Optional grant counters gcnt0/gcnt1 when RAM64_ARB_STATS_EN is defined.
module ram64_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_out
`ifdef RAM64_ARB_STATS_EN
    ,
    output logic [15:0]       gcnt0,
    output logic [15:0]       gcnt1
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_in_q, ram_in_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ram_write_q, ram_write_d;
    logic              port_q, port_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        arb_req, arb_gnt;

    // Arbitration only happens in an IDLE slot.
    assign arb_req = (state_q == IDLE) ? {req1, req0} : 2'b00;

    rr_arb2 #(
        .FAIR(FAIR)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req  (arb_req),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_in_d    = ram_in_q;
        rdata_d     = rdata_q;
        port_d      = port_q;
        ram_write_d = 1'b0;
        rvalid_d    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d     = ACCESS;
                    port_d      = arb_gnt[PORT1];
                    ram_write_d = arb_gnt[PORT1] ? we1 : we0;
                    ram_addr_d  = arb_gnt[PORT1] ? addr1 : addr0;
                    ram_in_d    = arb_gnt[PORT1] ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (!ram_write_q) begin
                    rdata_d          = ram_out;
                    rvalid_d[port_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_in_q    <= '0;
            rdata_q     <= '0;
            ram_write_q <= 1'b0;
            port_q      <= 1'b0;
            rvalid_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_in_q    <= ram_in_d;
            rdata_q     <= rdata_d;
            ram_write_q <= ram_write_d;
            port_q      <= port_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign gnt0      = arb_gnt[PORT0];
    assign gnt1      = arb_gnt[PORT1];
    assign rvalid0   = rvalid_q[PORT0];
    assign rvalid1   = rvalid_q[PORT1];
    assign rdata     = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_in    = ram_in_q;
    assign ram_write = ram_write_q;

`ifdef RAM64_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

    // Saturating grant counters.
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (arb_gnt[PORT0] && (gcnt0_q != 16'hFFFF)) gcnt0_d = gcnt0_q + 16'd1;
        if (arb_gnt[PORT1] && (gcnt1_q != 16'hFFFF)) gcnt1_d = gcnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule
